vga_scan_gen: RTL and testbench
===============================

// Module: vga_scan_gen
// PURPOSE
//  Raster scan generator. Produces the DrawX/DrawY pixel coordinates that every sprite hit-test block consumes.
//  Also produces the VGA sync and blank outputs, and per-line and per-frame strobes.
//  Game logic uses frame_start to update sprite positions between frames.
//  Sits between the system clock domain and the VGA DAC and all sprite/colour-mapper logic.
// PARAMETERS
//  H_VISIBLE 640  visible pixels per line
//  H_FP      16   horizontal front porch, in pixels
//  H_SYNC    96   horizontal sync width, in pixels
//  H_BP      48   horizontal back porch, in pixels
//  V_VISIBLE 480  visible lines per frame
//  V_FP      10   vertical front porch, in lines
//  V_SYNC    2    vertical sync width, in lines
//  V_BP      33   vertical back porch, in lines
//  Constraint: H_TOTAL = sum of the H_* parameters <= 1024.
//  Constraint: V_TOTAL = sum of the V_* parameters <= 1024.
// PORTS
//  Clk          in   1   system clock
//  Reset        in   1   synchronous reset, active-high
//  pix_ce       in   1   pixel-advance enable, one tick per pixel (unused when PIXEL_CLK_DIV_EN is defined)
//  DrawX        out  10  current pixel column = horizontal counter
//  DrawY        out  10  current pixel row = vertical counter
//  VGA_HS       out  1   horizontal sync, active-low
//  VGA_VS       out  1   vertical sync, active-low
//  VGA_BLANK_N  out  1   1 = visible region
//  line_start   out  1   one-Clk pulse when DrawX becomes 0
//  frame_start  out  1   one-Clk pulse when (DrawX,DrawY) becomes (0,0)
// BEHAVIOUR
//  - tick = pix_ce, or the internal divider tick (see CONFIGURATION). All state advances only on Clk edges where tick=1.
//  - Horizontal counter hc: on tick, hc increments; when hc = H_TOTAL-1 it wraps to 0.
//  - Vertical counter vc: increments on the tick where hc wraps; when vc = V_TOTAL-1 it wraps to 0.
//  - DrawX = hc and DrawY = vc, driven directly from the counter registers (no combinational path from inputs).
//  - Sync, blank and strobe outputs are registered and computed from the next counter values, so they align
//    with DrawX/DrawY in the same cycle:
//    - VGA_HS = 0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (defaults: 656..751).
//    - VGA_VS = 0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (defaults: 490..491).
//    - VGA_BLANK_N = 1 iff hc < H_VISIBLE && vc < V_VISIBLE.
//  - line_start and frame_start are high for exactly one Clk, the cycle the new counter value first appears.
//    They stay low while tick=0 holds the counters.
//  - Simultaneous events: on the hc wrap from H_TOTAL-1 with vc = V_TOTAL-1, both counters wrap on the same edge,
//    and line_start and frame_start both pulse.
//  - Reset values: hc = H_TOTAL-1, vc = V_TOTAL-1 (DrawX = 799, DrawY = 524 with defaults), VGA_HS = 1, VGA_VS = 1,
//    VGA_BLANK_N = 0, line_start = 0, frame_start = 0.
//  - Consequently, the first tick after reset goes to (0,0), pulses both strobes, and raises VGA_BLANK_N.
//  - Reset asserted mid-frame: all outputs return to reset values on the next Clk edge, regardless of tick.
//    No partial line or frame state is kept.
//  - tick held at 0: all outputs hold, and strobes stay 0.
// CONFIGURATION
//  - PIXEL_CLK_DIV_EN defined:
//    - pix_ce is ignored.
//    - Internal toggle register div (reset 0) flips every Clk; tick = div.
//    - Result is a divide-by-2 pixel rate (50 MHz Clk -> 25 MHz pixels).
//    - The first tick after reset release lands on the 2nd Clk edge.
//  - PIXEL_CLK_DIV_EN undefined: tick = pix_ce. There is no divider register.
// TESTING
//  1. Reset, then pix_ce = 1 for 1 Clk -> DrawX = 0, DrawY = 0, frame_start = 1, line_start = 1, VGA_BLANK_N = 1.
//  2. pix_ce = 1 continuously for 800 ticks from (0,0) -> VGA_HS = 0 exactly at DrawX 656..751 (96 ticks);
//     VGA_BLANK_N = 0 from DrawX 640; next line starts at DrawY = 1 with line_start = 1 and frame_start = 0.
//  3. Full frame of 420000 ticks -> frame_start pulses exactly twice (start and end);
//     VGA_VS = 0 only for DrawY 490..491 (1600 ticks).
//  4. pix_ce toggling 1,0,0,1 across a line boundary -> counters and outputs hold on 0 cycles;
//     line_start is 1 for a single Clk only.
//  5. Reset asserted at DrawX = 300, DrawY = 200 -> next Clk gives DrawX = 799, DrawY = 524, VGA_HS = 1, VGA_VS = 1,
//     VGA_BLANK_N = 0; the next tick gives (0,0) with frame_start = 1.
//  6. With PIXEL_CLK_DIV_EN and pix_ce tied to 0 -> DrawX advances once every 2 Clk;
//     the first advance is on the 2nd edge after Reset drops.

Source files
------------

// File: rtl/vga_scan_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_gen_if
//  Description : Bundle of the raster scan generator's pixel-enable input and
//                its scan outputs (coordinates, sync, blank, line/frame
//                strobes).
//                  master : the scan generator (drives coordinates/syncs)
//                  slave  : a consumer that supplies pix_ce and reads the scan
//  Ports       : pix_ce (to generator); DrawX, DrawY, VGA_HS, VGA_VS,
//                VGA_BLANK_N, line_start, frame_start (from generator)
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_scan_gen_if;
    logic       pix_ce;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       line_start;
    logic       frame_start;

    modport master (
        input  pix_ce,
        output DrawX, DrawY, VGA_HS, VGA_VS, VGA_BLANK_N, line_start, frame_start
    );

    modport slave (
        output pix_ce,
        input  DrawX, DrawY, VGA_HS, VGA_VS, VGA_BLANK_N, line_start, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_scan_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_gen
//  Description : Raster scan generator. Horizontal/vertical pixel counters
//                with registered active-low syncs, blank and one-clock
//                line/frame strobes, all aligned with DrawX/DrawY.
//  Ports       : Clk         - system clock
//                Reset       - synchronous reset, active-high
//                bus.pix_ce  - pixel-advance enable (ignored with divider)
//                bus.DrawX/DrawY, VGA_HS, VGA_VS, VGA_BLANK_N,
//                bus.line_start, bus.frame_start - scan outputs
//  Options     : `define PIXEL_CLK_DIV_EN -> internal divide-by-2 pixel tick
//                replaces pix_ce.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  wire logic       Clk,
    input  wire logic       Reset,
    vga_scan_gen_if.master  bus
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  c_H_LAST     = 10'(c_H_TOTAL - 1);
    localparam logic [9:0]  c_V_LAST     = 10'(c_V_TOTAL - 1);
    // Region bounds are 11 bits so an end bound equal to 1024 cannot wrap.
    localparam logic [10:0] c_H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] c_HS_START   = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] c_HS_END     = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] c_V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] c_VS_START   = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] c_VS_END     = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic       w_tick;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic [9:0] w_hc_next;
    logic [9:0] w_vc_next;

    logic [9:0] r_hc;
    logic [9:0] r_vc;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank_n;
    logic       r_line_start;
    logic       r_frame_start;

`ifdef PIXEL_CLK_DIV_EN
    logic r_div;
    logic w_unused_pix_ce;

    assign w_unused_pix_ce = bus.pix_ce;

    // Toggle starts at 0, so the first tick lands on the 2nd edge after reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_div <= 1'b0;
        end else begin
            r_div <= ~r_div;
        end
    end

    assign w_tick = r_div;
`else
    assign w_tick = bus.pix_ce;
`endif

    assign w_h_wrap  = (r_hc == c_H_LAST);
    assign w_v_wrap  = (r_vc == c_V_LAST);
    assign w_hc_next = w_h_wrap ? 10'd0 : r_hc + 10'd1;
    assign w_vc_next = !w_h_wrap ? r_vc :
                       (w_v_wrap ? 10'd0 : r_vc + 10'd1);

    // Sync/blank/strobes are computed from the next counter values so that
    // they change on the same edge as DrawX/DrawY.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hc          <= c_H_LAST;
            r_vc          <= c_V_LAST;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank_n     <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (w_tick) begin
                r_hc          <= w_hc_next;
                r_vc          <= w_vc_next;
                r_hs          <= !(({1'b0, w_hc_next} >= c_HS_START) &&
                                   ({1'b0, w_hc_next} <  c_HS_END));
                r_vs          <= !(({1'b0, w_vc_next} >= c_VS_START) &&
                                   ({1'b0, w_vc_next} <  c_VS_END));
                r_blank_n     <= ({1'b0, w_hc_next} < c_H_VIS) &&
                                 ({1'b0, w_vc_next} < c_V_VIS);
                r_line_start  <= w_h_wrap;
                r_frame_start <= w_h_wrap && w_v_wrap;
            end
        end
    end

    assign bus.DrawX       = r_hc;
    assign bus.DrawY       = r_vc;
    assign bus.VGA_HS      = r_hs;
    assign bus.VGA_VS      = r_vs;
    assign bus.VGA_BLANK_N = r_blank_n;
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_scan_gen
//  Description : Scoreboard bench for vga_scan_gen. Two instances share clock,
//                reset and pix_ce: a small-timing one (many whole frames) and
//                a default-timing one (reset values, first lines). The
//                reference model tracks a linear pixel position in the frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_gen;

    // Small timing: 28 x 13 = 364 pixels per frame.
    localparam int S_HV = 16, S_HF = 3, S_HS = 4, S_HB = 5;
    localparam int S_VV = 6,  S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int D_HV = 640, D_HF = 16, D_HS = 96, D_HB = 48;
    localparam int D_VV = 480, D_VF = 10, D_VS = 2,  D_VB = 33;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       ls;
        logic       fs;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    logic pix_ce;

    always #5 Clk = ~Clk;

    vga_scan_gen_if bus_s();
    vga_scan_gen_if bus_d();

    assign bus_s.pix_ce = pix_ce;
    assign bus_d.pix_ce = pix_ce;

    vga_scan_gen #(
        .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) u_small (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_s)
    );

    vga_scan_gen u_def (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_d)
    );

    exp_t q_s[$];
    exp_t q_d[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   running     = 1'b1;

    // Model state: linear position within the frame, plus divider phase.
    int   pos_s;
    int   pos_d;
    bit   div_m;

    function automatic exp_t model_out(int pos, bit strobe,
                                       int hv, int hf, int hsw, int hb,
                                       int vv, int vf, int vsw);
        exp_t e;
        int ht = hv + hf + hsw + hb;
        int x  = pos % ht;
        int y  = pos / ht;
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.hs = !(x >= hv + hf && x < hv + hf + hsw);
        e.vs = !(y >= vv + vf && y < vv + vf + vsw);
        e.bn = (x < hv) && (y < vv);
        e.ls = strobe && (x == 0);
        e.fs = strobe && (pos == 0);
        return e;
    endfunction

    function automatic string fmt(exp_t e);
        return $sformatf("x=%0d y=%0d hs=%b vs=%b bn=%b ls=%b fs=%b",
                         e.x, e.y, e.hs, e.vs, e.bn, e.ls, e.fs);
    endfunction

    // Apply one clock of stimulus and push the expected post-edge state.
    task automatic step(input bit rst, input bit ce);
        bit tick;
        bit strobe;
        int fr_s = (S_HV + S_HF + S_HS + S_HB) * (S_VV + S_VF + S_VS + S_VB);
        int fr_d = (D_HV + D_HF + D_HS + D_HB) * (D_VV + D_VF + D_VS + D_VB);
        Reset  = rst;
        pix_ce = ce;
`ifdef PIXEL_CLK_DIV_EN
        tick = div_m;
`else
        tick = ce;
`endif
        if (rst) begin
            pos_s  = fr_s - 1;
            pos_d  = fr_d - 1;
            div_m  = 1'b0;
            strobe = 1'b0;
        end else begin
            div_m  = ~div_m;
            strobe = tick;
            if (tick) begin
                pos_s = (pos_s + 1) % fr_s;
                pos_d = (pos_d + 1) % fr_d;
            end
        end
        q_s.push_back(model_out(pos_s, strobe, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS));
        q_d.push_back(model_out(pos_d, strobe, D_HV, D_HF, D_HS, D_HB, D_VV, D_VF, D_VS));
        @(posedge Clk);
        #1;
    endtask

    // Monitor: every falling edge the DUTs present a new scan state.
    always @(negedge Clk) begin
        exp_t a;
        exp_t e;
        if (running) begin
            a = '{bus_s.DrawX, bus_s.DrawY, bus_s.VGA_HS, bus_s.VGA_VS,
                  bus_s.VGA_BLANK_N, bus_s.line_start, bus_s.frame_start};
            vectors++;
            if (q_s.size() == 0) begin
                miscompares++;
                $display("FAIL small: output %s with no expectation queued", fmt(a));
            end else begin
                e = q_s.pop_front();
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL small @%0t: got %s, expected %s", $time, fmt(a), fmt(e));
                end
            end
            a = '{bus_d.DrawX, bus_d.DrawY, bus_d.VGA_HS, bus_d.VGA_VS,
                  bus_d.VGA_BLANK_N, bus_d.line_start, bus_d.frame_start};
            vectors++;
            if (q_d.size() == 0) begin
                miscompares++;
                $display("FAIL default: output %s with no expectation queued", fmt(a));
            end else begin
                e = q_d.pop_front();
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL default @%0t: got %s, expected %s", $time, fmt(a), fmt(e));
                end
            end
        end
    end

    initial begin
        pos_s = 0;
        pos_d = 0;
        div_m = 1'b0;

        // Reset, then a single tick to (0,0).
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        // Hold: outputs frozen, strobes low.
        repeat (3) step(1'b0, 1'b0);
        // Continuous ticks over two whole small frames.
        repeat (2 * 364 + 5) step(1'b0, 1'b1);
        // Sparse random ticks, crossing many line boundaries.
        repeat (1500) step(1'b0, $urandom_range(0, 3) != 0);
        // Reset mid-frame followed by restart.
        repeat (217) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        // Random ticks with occasional reset.
        repeat (2500) step($urandom_range(0, 399) == 0, $urandom_range(0, 1) != 0);

        @(negedge Clk);
        #1;
        running = 1'b0;
        if (q_s.size() != 0 || q_d.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d expectations left, expected 0/0", q_s.size(), q_d.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
